// File: rtl/iic_slave_responder.sv
// I2C target that emulates a 16-byte register device (default address 0x50).
// The bus side supports write, random read and current-address read.
// The fabric side has a register preload/readback port and a bus-write strobe.
// The SCL/SDA inputs are synchronised and glitch-filtered before any decoding.
// All SDA_OE changes are delayed HOLD_CYC cycles after the filtered SCL fall.
module iic_slave_responder #(
    parameter logic [6:0] DEV_ADDR   = 7'b101_0000,
    parameter int         FILTER_LEN = 4,
    parameter int         HOLD_CYC   = 60
) (
    input  logic       CLK_200M,
    input  logic       SYS_RSTn,
    input  logic       SCL_IN,
    input  logic       SDA_IN,
    output logic       SDA_OE,
    input  logic       REG_WE,
    input  logic [3:0] REG_ADDR,
    input  logic [7:0] REG_WD,
    output logic [7:0] REG_RD,
    output logic       BUS_WR_STB,
    output logic [3:0] BUS_WR_ADDR,
    output logic [7:0] BUS_WR_DATA,
    output logic       BUSY
);

    localparam logic [3:0]        FLT_LAST  = 4'(FILTER_LEN - 1);
    localparam int                HOLD_W    = $clog2(HOLD_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DEVADR   = 3'd1;
    localparam logic [2:0] ST_WORDADR  = 3'd2;
    localparam logic [2:0] ST_WRITE    = 3'd3;
    localparam logic [2:0] ST_READ     = 3'd4;
    localparam logic [2:0] ST_WAITSTOP = 3'd5;

    logic              scl_p0, scl_p1, sda_p0, sda_p1;
    logic [3:0]        scl_cnt, sda_cnt;
    logic              scl_flt, sda_flt;
    logic              scl_prev, sda_prev;
    logic              start_ev, stop_ev, rise_ev, fall_ev;
    logic [2:0]        state;
    logic [3:0]        bit_cnt;
    logic [7:0]        shreg;
    logic [7:0]        shift_in;
    logic [3:0]        ptr;
    logic              rd_req;
    logic              mst_ack;
    logic              oe_pend;
    logic [HOLD_W-1:0] hold_cnt;
    logic              addr_hit;
    logic              bus_we;
    logic [2:0]        rd_idx;
    logic [7:0]        mem [16];

    // Two-flop synchronisers; idle bus level is high
    always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
        if (!SYS_RSTn) begin
            scl_p0 <= 1'b1;
            scl_p1 <= 1'b1;
            sda_p0 <= 1'b1;
            sda_p1 <= 1'b1;
        end else begin
            scl_p0 <= SCL_IN;
            scl_p1 <= scl_p0;
            sda_p0 <= SDA_IN;
            sda_p1 <= sda_p0;
        end
    end

    // Glitch filter: accept a new level only after FILTER_LEN consecutive equal samples
    always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
        if (!SYS_RSTn) begin
            scl_cnt <= '0;
            sda_cnt <= '0;
            scl_flt <= 1'b1;
            sda_flt <= 1'b1;
        end else begin
            if (scl_p1 == scl_flt) begin
                scl_cnt <= '0;
            end else if (scl_cnt == FLT_LAST) begin
                scl_flt <= scl_p1;
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 4'd1;
            end
            if (sda_p1 == sda_flt) begin
                sda_cnt <= '0;
            end else if (sda_cnt == FLT_LAST) begin
                sda_flt <= sda_p1;
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 4'd1;
            end
        end
    end

    // Previous filtered levels for edge detection
    always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
        if (!SYS_RSTn) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_flt;
            sda_prev <= sda_flt;
        end
    end

    // SDA edges while SCL is high take priority over a coincident SCL edge
    assign start_ev = scl_flt & sda_prev & ~sda_flt;
    assign stop_ev  = scl_flt & ~sda_prev & sda_flt;
    assign rise_ev  = scl_flt & ~scl_prev & ~start_ev & ~stop_ev;
    assign fall_ev  = ~scl_flt & scl_prev;
    assign shift_in = {shreg[6:0], sda_flt};
    assign addr_hit = (shift_in[7:1] == DEV_ADDR);
    assign bus_we   = rise_ev && (state == ST_WRITE) && (bit_cnt == 4'd7);
    assign rd_idx   = 3'(4'd7 - bit_cnt);

    // Protocol sequencer plus the delayed SDA_OE update
    always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
        if (!SYS_RSTn) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            ptr      <= '0;
            rd_req   <= 1'b0;
            mst_ack  <= 1'b0;
            oe_pend  <= 1'b0;
            hold_cnt <= '0;
            SDA_OE   <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            if (hold_cnt == HOLD_W'(1)) begin
                SDA_OE   <= oe_pend;
                hold_cnt <= '0;
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end

            if (start_ev) begin
                state    <= ST_DEVADR;
                bit_cnt  <= '0;
                SDA_OE   <= 1'b0;
                oe_pend  <= 1'b0;
                hold_cnt <= '0;
            end else if (stop_ev) begin
                state    <= ST_IDLE;
                bit_cnt  <= '0;
                SDA_OE   <= 1'b0;
                oe_pend  <= 1'b0;
                hold_cnt <= '0;
                BUSY     <= 1'b0;
            end else if (rise_ev) begin
                case (state)
                    ST_DEVADR, ST_WORDADR, ST_WRITE: begin
                        if (bit_cnt < 4'd8) begin
                            shreg   <= shift_in;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                if (state == ST_DEVADR) begin
                                    if (addr_hit) begin
                                        rd_req <= shift_in[0];
                                        BUSY   <= 1'b1;
                                    end else begin
                                        state   <= ST_WAITSTOP;
                                        bit_cnt <= '0;
                                    end
                                end else if (state == ST_WORDADR) begin
                                    ptr <= shift_in[3:0];
                                end else begin
                                    ptr <= ptr + 4'd1;
                                end
                            end
                        end else if (bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd9;
                        end
                    end
                    ST_READ: begin
                        if (bit_cnt == 4'd8) begin
                            mst_ack <= ~sda_flt;
                        end
                        if (bit_cnt < 4'd9) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end else if (fall_ev) begin
                case (state)
                    ST_DEVADR, ST_WORDADR, ST_WRITE: begin
                        if (bit_cnt == 4'd8) begin
                            oe_pend  <= 1'b1;
                            hold_cnt <= HOLD_LOAD;
                        end else if (bit_cnt == 4'd9) begin
                            bit_cnt  <= '0;
                            oe_pend  <= 1'b0;
                            hold_cnt <= HOLD_LOAD;
                            if (state == ST_DEVADR && rd_req) begin
                                state   <= ST_READ;
                                shreg   <= mem[ptr];
                                ptr     <= ptr + 4'd1;
                                oe_pend <= ~mem[ptr][7];
                            end else if (state == ST_DEVADR) begin
                                state <= ST_WORDADR;
                            end else if (state == ST_WORDADR) begin
                                state <= ST_WRITE;
                            end
                        end
                    end
                    ST_READ: begin
                        if (bit_cnt != 4'd0 && bit_cnt <= 4'd7) begin
                            oe_pend  <= ~shreg[rd_idx];
                            hold_cnt <= HOLD_LOAD;
                        end else if (bit_cnt == 4'd8) begin
                            oe_pend  <= 1'b0;
                            hold_cnt <= HOLD_LOAD;
                        end else if (bit_cnt == 4'd9) begin
                            bit_cnt  <= '0;
                            hold_cnt <= HOLD_LOAD;
                            if (mst_ack) begin
                                shreg   <= mem[ptr];
                                ptr     <= ptr + 4'd1;
                                oe_pend <= ~mem[ptr][7];
                            end else begin
                                state   <= ST_WAITSTOP;
                                oe_pend <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Register file: a bus write is applied last so it wins an address collision
    always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
        if (!SYS_RSTn) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (REG_WE) begin
                mem[REG_ADDR] <= REG_WD;
            end
            if (bus_we) begin
                mem[ptr] <= shift_in;
            end
        end
    end

    // Fabric readback and bus-write notification
    always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
        if (!SYS_RSTn) begin
            REG_RD      <= '0;
            BUS_WR_STB  <= 1'b0;
            BUS_WR_ADDR <= '0;
            BUS_WR_DATA <= '0;
        end else begin
            REG_RD     <= mem[REG_ADDR];
            BUS_WR_STB <= bus_we;
            if (bus_we) begin
                BUS_WR_ADDR <= ptr;
                BUS_WR_DATA <= shift_in;
            end
        end
    end

endmodule

// File: tb/tb_iic_slave_responder.sv
// Bench for iic_slave_responder: a bit-level I2C master drives the bus.
// A transaction-level register/pointer model predicts read data, memory contents and write strobes.
`timescale 1ns/100ps
module tb_iic_slave_responder;

    localparam int H = 80;  // SCL half period in clock cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_oe;
    logic       sda_bus;
    logic       reg_we = 1'b0;
    logic [3:0] reg_addr = '0;
    logic [7:0] reg_wd = '0;
    logic [7:0] reg_rd;
    logic       bus_wr_stb;
    logic [3:0] bus_wr_addr;
    logic [7:0] bus_wr_data;
    logic       busy;

    assign sda_bus = m_sda & ~sda_oe;

    iic_slave_responder dut (
        .CLK_200M   (clk),
        .SYS_RSTn   (rst_n),
        .SCL_IN     (m_scl),
        .SDA_IN     (sda_bus),
        .SDA_OE     (sda_oe),
        .REG_WE     (reg_we),
        .REG_ADDR   (reg_addr),
        .REG_WD     (reg_wd),
        .REG_RD     (reg_rd),
        .BUS_WR_STB (bus_wr_stb),
        .BUS_WR_ADDR(bus_wr_addr),
        .BUS_WR_DATA(bus_wr_data),
        .BUSY       (busy)
    );

    always #2.5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  ref_mem [16];
    logic [3:0]  ref_ptr;
    logic [11:0] strb_log [$];
    logic [11:0] exp_log [$];
    int          oe_cnt = 0;
    logic        glitch_en = 1'b0;

    always @(negedge clk) begin
        if (bus_wr_stb) strb_log.push_back({bus_wr_addr, bus_wr_data});
        if (sda_oe) oe_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b, output logic smp, output logic oe_hi);
        wait_cyc(H / 4);
        m_sda = b;
        if (glitch_en) begin
            wait_cyc(H / 4);
            m_scl = 1'b1;
            wait_cyc(2);
            m_scl = 1'b0;
            wait_cyc(H / 2 - 2);
        end else begin
            wait_cyc(3 * H / 4);
        end
        m_scl = 1'b1;
        wait_cyc(H / 4);
        if (glitch_en) begin
            m_sda = ~b;
            wait_cyc(2);
            m_sda = b;
            wait_cyc(H / 4 - 2);
        end else begin
            wait_cyc(H / 4);
        end
        smp   = sda_bus;
        oe_hi = sda_oe;
        wait_cyc(H / 2);
        m_scl = 1'b0;
    endtask

    task automatic start_cond();
        wait_cyc(H);
        m_sda = 1'b1;
        wait_cyc(H / 2);
        m_scl = 1'b1;
        wait_cyc(H / 2);
        m_sda = 1'b0;
        wait_cyc(H / 2);
        m_scl = 1'b0;
    endtask

    task automatic stop_cond();
        wait_cyc(H);
        m_sda = 1'b0;
        wait_cyc(H / 2);
        m_scl = 1'b1;
        wait_cyc(H / 2);
        m_sda = 1'b1;
        wait_cyc(H);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked, output logic oe_ack);
        logic s, o;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s, o);
        clock_bit(1'b1, s, o);
        acked  = ~s;
        oe_ack = o;
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        logic s, o;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, s, o);
            d = {d[6:0], s};
        end
        clock_bit(~mack, s, o);
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        reg_we = 1'b1; reg_addr = a; reg_wd = d;
        @(negedge clk);
        reg_we = 1'b0;
    endtask

    task automatic reg_read(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        reg_addr = a;
        @(negedge clk);
        d = reg_rd;
    endtask

    // Reference model: byte-level register device with an auto-incrementing pointer
    task automatic model_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        ref_ptr = 4'h0;
    endtask

    task automatic model_wbyte(input logic [7:0] b);
        ref_mem[ref_ptr] = b;
        exp_log.push_back({ref_ptr, b});
        ref_ptr = ref_ptr + 4'd1;
    endtask

    task automatic model_rbyte(output logic [7:0] b);
        b = ref_mem[ref_ptr];
        ref_ptr = ref_ptr + 4'd1;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        model_reset();
        rst_n = 1'b0;
        wait_cyc(5);
        n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (bus_wr_stb !== 1'b0) begin n_err++; $display("FAIL reset_stb got=%b exp=0", bus_wr_stb); end
        n_cmp++; if ({bus_wr_addr, bus_wr_data} !== 12'h000) begin n_err++; $display("FAIL reset_wr_bus got=%h exp=000", {bus_wr_addr, bus_wr_data}); end
        n_cmp++; if (reg_rd !== 8'h00) begin n_err++; $display("FAIL reset_reg_rd got=%h exp=00", reg_rd); end
        rst_n = 1'b1;
        wait_cyc(10);
        for (int i = 0; i < 16; i += 5) begin
            reg_read(4'(i), d);
            n_cmp++; if (d !== ref_mem[i]) begin n_err++; $display("FAIL reset_mem[%0d] got=%h exp=%h", i, d, ref_mem[i]); end
        end
    endtask

    task automatic test_preload_read();
        logic a, o;
        logic [7:0] d, e;
        reg_write(4'd6, 8'h08);
        ref_mem[6] = 8'h08;
        start_cond();
        send_byte(8'hA0, a, o);
        n_cmp++; if ({a, o} !== 2'b11) begin n_err++; $display("FAIL ack_bit9 got=%b exp=11", {a, o}); end
        send_byte(8'h06, a, o);
        n_cmp++; if ({a, o} !== 2'b11) begin n_err++; $display("FAIL ack_bit18 got=%b exp=11", {a, o}); end
        ref_ptr = 4'h6;
        start_cond();
        send_byte(8'hA1, a, o);
        n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL ack_read_addr got=%b exp=1", a); end
        recv_byte(1'b0, d);
        model_rbyte(e);
        n_cmp++; if (d !== e) begin n_err++; $display("FAIL preload_read got=%h exp=%h", d, e); end
        wait_cyc(H);
        n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL release_after_nack got=%b exp=0", sda_oe); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_in_xfer got=%b exp=1", busy); end
        stop_cond();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_after_stop got=%b exp=0", busy); end
    endtask

    task automatic test_write_wrap();
        logic a, o, ok;
        logic [7:0] d;
        logic [7:0] seq [4];
        seq[0] = 8'hA0; seq[1] = 8'h0F; seq[2] = 8'h11; seq[3] = 8'h22;
        ok = 1'b1;
        start_cond();
        for (int i = 0; i < 4; i++) begin
            send_byte(seq[i], a, o);
            ok = ok & a;
        end
        stop_cond();
        ref_ptr = 4'hF;
        model_wbyte(8'h11);
        model_wbyte(8'h22);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL wrap_acks got=%b exp=1", ok); end
        n_cmp++; if (strb_log.size() !== exp_log.size()) begin n_err++; $display("FAIL wrap_stb_count got=%0d exp=%0d", strb_log.size(), exp_log.size()); end
        for (int i = 0; i < exp_log.size() && i < strb_log.size(); i++) begin
            n_cmp++; if (strb_log[i] !== exp_log[i]) begin n_err++; $display("FAIL wrap_stb[%0d] got=%h exp=%h", i, strb_log[i], exp_log[i]); end
        end
        reg_read(4'hF, d);
        n_cmp++; if (d !== ref_mem[15]) begin n_err++; $display("FAIL wrap_mem15 got=%h exp=%h", d, ref_mem[15]); end
        reg_read(4'h0, d);
        n_cmp++; if (d !== ref_mem[0]) begin n_err++; $display("FAIL wrap_mem0 got=%h exp=%h", d, ref_mem[0]); end
    endtask

    task automatic test_mismatch();
        logic a, o;
        logic [7:0] d;
        int c0, s0;
        c0 = oe_cnt;
        s0 = strb_log.size();
        start_cond();
        send_byte(8'hA2, a, o);
        n_cmp++; if (a !== 1'b0) begin n_err++; $display("FAIL mismatch_ack got=%b exp=0", a); end
        send_byte(8'h5A, a, o);
        n_cmp++; if (a !== 1'b0) begin n_err++; $display("FAIL mismatch_data_ack got=%b exp=0", a); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mismatch_busy got=%b exp=0", busy); end
        stop_cond();
        n_cmp++; if (oe_cnt !== c0) begin n_err++; $display("FAIL mismatch_oe_cycles got=%0d exp=%0d", oe_cnt - c0, 0); end
        n_cmp++; if (strb_log.size() !== s0) begin n_err++; $display("FAIL mismatch_stb got=%0d exp=%0d", strb_log.size(), s0); end
        for (int i = 0; i < 16; i++) begin
            reg_read(4'(i), d);
            n_cmp++; if (d !== ref_mem[i]) begin n_err++; $display("FAIL mismatch_mem[%0d] got=%h exp=%h", i, d, ref_mem[i]); end
        end
    endtask

    task automatic test_partial_stop();
        logic a, o, ok, s;
        logic [7:0] d, e, part;
        ok = 1'b1;
        part = 8'hAA;
        start_cond();
        send_byte(8'hA0, a, o); ok = ok & a;
        send_byte(8'h03, a, o); ok = ok & a;
        send_byte(8'h55, a, o); ok = ok & a;
        for (int i = 7; i >= 4; i--) clock_bit(part[i], s, o);
        stop_cond();
        ref_ptr = 4'h3;
        model_wbyte(8'h55);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL partial_acks got=%b exp=1", ok); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL partial_busy got=%b exp=0", busy); end
        n_cmp++; if (strb_log.size() !== exp_log.size()) begin n_err++; $display("FAIL partial_stb_count got=%0d exp=%0d", strb_log.size(), exp_log.size()); end
        reg_read(4'h3, d);
        n_cmp++; if (d !== ref_mem[3]) begin n_err++; $display("FAIL partial_mem3 got=%h exp=%h", d, ref_mem[3]); end
        reg_read(4'h4, d);
        n_cmp++; if (d !== ref_mem[4]) begin n_err++; $display("FAIL partial_mem4 got=%h exp=%h", d, ref_mem[4]); end
        // current-address read continues from the pointer left by the write
        start_cond();
        send_byte(8'hA1, a, o);
        n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL curaddr_ack got=%b exp=1", a); end
        recv_byte(1'b0, d);
        model_rbyte(e);
        n_cmp++; if (d !== e) begin n_err++; $display("FAIL curaddr_read got=%h exp=%h", d, e); end
        stop_cond();
    endtask

    task automatic test_glitch();
        logic a, o, ok;
        logic [7:0] w, b0, b1, d;
        int c0;
        c0 = oe_cnt;
        m_scl = 1'b0; wait_cyc(2); m_scl = 1'b1; wait_cyc(20);
        m_sda = 1'b0; wait_cyc(2); m_sda = 1'b1; wait_cyc(20);
        n_cmp++; if ({busy, sda_oe} !== 2'b00 || oe_cnt !== c0) begin n_err++; $display("FAIL idle_glitch got=%b/%0d exp=00/0", {busy, sda_oe}, oe_cnt - c0); end
        w  = 8'($urandom);
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        ok = 1'b1;
        start_cond();
        glitch_en = 1'b1;
        send_byte(8'hA0, a, o); ok = ok & a;
        send_byte(w, a, o);     ok = ok & a;
        send_byte(b0, a, o);    ok = ok & a;
        send_byte(b1, a, o);    ok = ok & a;
        glitch_en = 1'b0;
        stop_cond();
        ref_ptr = w[3:0];
        model_wbyte(b0);
        model_wbyte(b1);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL glitch_acks got=%b exp=1", ok); end
        reg_read(w[3:0], d);
        n_cmp++; if (d !== ref_mem[w[3:0]]) begin n_err++; $display("FAIL glitch_mem_a got=%h exp=%h", d, ref_mem[w[3:0]]); end
        reg_read(w[3:0] + 4'd1, d);
        n_cmp++; if (d !== ref_mem[w[3:0] + 4'd1]) begin n_err++; $display("FAIL glitch_mem_b got=%h exp=%h", d, ref_mem[w[3:0] + 4'd1]); end
        n_cmp++; if (strb_log.size() !== exp_log.size()) begin n_err++; $display("FAIL glitch_stb_count got=%0d exp=%0d", strb_log.size(), exp_log.size()); end
    endtask

    task automatic test_reset_mid_read();
        logic a, o, ok;
        logic [7:0] w, b, d, e;
        reg_write(4'd9, 8'h3C);
        ref_mem[9] = 8'h3C;
        start_cond();
        send_byte(8'hA0, a, o);
        send_byte(8'h09, a, o);
        start_cond();
        send_byte(8'hA1, a, o);
        wait_cyc(H - 5);
        n_cmp++; if (sda_oe !== 1'b1) begin n_err++; $display("FAIL driving_before_reset got=%b exp=1", sda_oe); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL oe_async_release got=%b exp=0", sda_oe); end
        m_scl = 1'b1;
        m_sda = 1'b1;
        wait_cyc(5);
        rst_n = 1'b1;
        model_reset();
        strb_log.delete();
        exp_log.delete();
        wait_cyc(20);
        w = {4'($urandom), 4'($urandom)};
        b = 8'($urandom);
        ok = 1'b1;
        start_cond();
        send_byte(8'hA0, a, o); ok = ok & a;
        send_byte(w, a, o);     ok = ok & a;
        send_byte(b, a, o);     ok = ok & a;
        ref_ptr = w[3:0];
        model_wbyte(b);
        start_cond();
        send_byte(8'hA0, a, o); ok = ok & a;
        send_byte(w, a, o);     ok = ok & a;
        ref_ptr = w[3:0];
        start_cond();
        send_byte(8'hA1, a, o); ok = ok & a;
        recv_byte(1'b0, d);
        model_rbyte(e);
        stop_cond();
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL post_reset_acks got=%b exp=1", ok); end
        n_cmp++; if (d !== e) begin n_err++; $display("FAIL post_reset_read got=%h exp=%h", d, e); end
    endtask

    task automatic test_random();
        logic a, o, ok;
        logic [7:0] w, b, d, e;
        logic [3:0] ra;
        int kind, n;
        for (int t = 0; t < 3; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                ra = 4'($urandom);
                b  = 8'($urandom);
                reg_write(ra, b);
                ref_mem[ra] = b;
            end
            kind = $urandom_range(0, 2);
            n    = $urandom_range(1, 2);
            ok   = 1'b1;
            start_cond();
            if (kind == 0) begin
                w = 8'($urandom);
                send_byte(8'hA0, a, o); ok = ok & a;
                send_byte(w, a, o);     ok = ok & a;
                ref_ptr = w[3:0];
                for (int k = 0; k < n; k++) begin
                    b = 8'($urandom);
                    send_byte(b, a, o); ok = ok & a;
                    model_wbyte(b);
                end
            end else begin
                if (kind == 1) begin
                    w = 8'($urandom);
                    send_byte(8'hA0, a, o); ok = ok & a;
                    send_byte(w, a, o);     ok = ok & a;
                    ref_ptr = w[3:0];
                    start_cond();
                end
                send_byte(8'hA1, a, o); ok = ok & a;
                for (int k = 0; k < n; k++) begin
                    recv_byte(k != n - 1, d);
                    model_rbyte(e);
                    n_cmp++; if (d !== e) begin n_err++; $display("FAIL rand_read t%0d k%0d got=%h exp=%h", t, k, d, e); end
                end
            end
            stop_cond();
            n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rand_acks t%0d got=%b exp=1", t, ok); end
        end
        n_cmp++; if (strb_log.size() !== exp_log.size()) begin n_err++; $display("FAIL rand_stb_count got=%0d exp=%0d", strb_log.size(), exp_log.size()); end
        for (int i = 0; i < exp_log.size() && i < strb_log.size(); i++) begin
            n_cmp++; if (strb_log[i] !== exp_log[i]) begin n_err++; $display("FAIL rand_stb[%0d] got=%h exp=%h", i, strb_log[i], exp_log[i]); end
        end
        for (int i = 0; i < 16; i++) begin
            reg_read(4'(i), d);
            n_cmp++; if (d !== ref_mem[i]) begin n_err++; $display("FAIL rand_mem[%0d] got=%h exp=%h", i, d, ref_mem[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_preload_read();
        test_write_wrap();
        test_mismatch();
        test_partial_stop();
        test_glitch();
        test_reset_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/iic_slave_responder.md
Name: iic_slave_responder

Overview:
- I2C device-side responder on CLK_200M; the target end of the bus that the team's IIC master drives.
- Emulates a 16-byte register device at a parameterised 7-bit address; default matches the SFP ID EEPROM (0x50).
- Used on-board as an emulated SFP EEPROM for the SGMII/1000BASE-X detect path, and in benches as the master's counterpart.
- Fabric side has a register preload/readback port and a bus-write strobe.

Parameters:
- DEV_ADDR, 7'b101_0000, 7-bit device address this block ACKs.
- FILTER_LEN, 4, consecutive identical synchronised samples required before SCL_IN/SDA_IN are accepted (1..15).
- HOLD_CYC, 60, CLK_200M cycles from filtered SCL fall to any SDA_OE change (300 ns).

Ports:
- CLK_200M  in  1  system clock, 200 MHz.
- SYS_RSTn  in  1  asynchronous, active-low reset.
- SCL_IN  in  1  bus clock from pad, asynchronous.
- SDA_IN  in  1  bus data from pad, asynchronous.
- SDA_OE  out  1  1 = pull SDA low (open drain); 0 = release.
- REG_WE  in  1  fabric register write strobe.
- REG_ADDR  in  4  fabric register address.
- REG_WD  in  8  fabric write data.
- REG_RD  out  8  mem[REG_ADDR], registered, 1-cycle latency.
- BUS_WR_STB  out  1  1-cycle pulse when a bus data byte is written.
- BUS_WR_ADDR  out  4  address of that write; valid with the strobe.
- BUS_WR_DATA  out  8  data of that write; valid with the strobe.
- BUSY  out  1  1 from an addressed START to the following STOP.

Behaviour:
- Reset values: SDA_OE=0, REG_RD=0, BUS_WR_STB=0, BUS_WR_ADDR=0, BUS_WR_DATA=0, BUSY=0, all 16 registers=0x00, pointer=0, state IDLE.
- Input conditioning:
  - 2-flop synchroniser on each line, then a per-line filter.
  - The filtered value changes only after FILTER_LEN equal samples; filtered values reset to 1.
  - All edges below refer to filtered signals.
- Bus events:
  - START = SDA fall while SCL high.
  - STOP = SDA rise while SCL high.
  - Data is sampled on SCL rise; SDA_OE changes only HOLD_CYC cycles after SCL fall.
- States and transitions:
  - IDLE: waits for START, then goes to DEVADR.
  - DEVADR: shifts 8 bits, MSB first.
    - Address match, R/W=0: ACK, then WORDADR.
    - Address match, R/W=1: ACK, then READ.
    - Mismatch: no ACK, go to WAITSTOP.
  - WORDADR: shifts 8 bits; pointer <= byte[3:0] (upper bits ignored); ACK, then WRITE.
  - WRITE: shifts 8 bits.
    - After the 8th SCL rise: mem[pointer] <= byte; BUS_WR_STB pulses with the pre-increment pointer and the byte.
    - Pointer increments mod 16; ACK; stay in WRITE.
  - READ:
    - On the SCL fall that ends the preceding ACK: shift register <= mem[pointer], pointer increments mod 16.
    - Drives 8 bits (SDA_OE = ~bit), then releases SDA for the master ACK bit.
    - Master ACK (SDA=0): reload and continue.
    - Master NACK: go to WAITSTOP.
  - WAITSTOP: SDA released; waits for STOP or START.
- ACK bit: SDA_OE=1 from HOLD_CYC after the 8th SCL fall until HOLD_CYC after the 9th SCL fall.
- START received in any state, including mid-byte (repeated START): bit counter cleared, SDA released, go to DEVADR, pointer kept.
- STOP received in any state: go to IDLE, SDA released, BUSY=0. A partial byte is discarded and never written.
- Pointer persists across transactions. A current-address read (START, addr+R) uses the last pointer.
- Collisions:
  - Bus write and REG_WE in the same cycle, same address: bus write wins.
  - Different addresses: both take effect.
- No clock stretching. SCL high and SDA both changing in one cycle resolves as START/STOP by SDA direction.
- Async reset mid-transfer releases SDA immediately and returns to IDLE.

Test Plan:
- REG_WE addr 6 data 0x08, then bus read at 0xA0/0xA1 with word address 0x06, 1 byte with NACK -> master reads 0x08; ACKs seen at bits 9 and 18; SDA released after NACK.
- Bus write 0xA0, 0x0F, 0x11, 0x22 -> mem[15]=0x11, mem[0]=0x22 (wrap); BUS_WR_STB twice with (0xF,0x11) then (0x0,0x22); REG_RD confirms both.
- Address 0xA2 (mismatch) -> no ACK, SDA_OE stays 0 until STOP, BUSY=0, registers unchanged.
- Write 0xA0, 0x03, 0x55, then STOP after 4 bits of a second data byte -> mem[3]=0x55, mem[4] unchanged, state IDLE.
- 2-cycle glitches on SCL and SDA with FILTER_LEN=4 -> no state change and no spurious START/STOP.
- Assert SYS_RSTn=0 while the block drives SDA low during a read -> SDA_OE=0 the same cycle; after release, next transaction works normally.
